// File: rtl/rf_dump_pkg.sv
// -----------------------------------------------------------------------------
// rf_dump_pkg
//   Shared constants for the register-file dump sequencer:
//     - default geometry (register count, select/data widths, read latency)
//     - default halt sentinel PC that auto-triggers a dump
//     - FSM state encodings (kept as plain localparam constants so the
//       encoding matches the legacy Verilog netlists)
//   No ports (package).
// -----------------------------------------------------------------------------
package rf_dump_pkg;

    localparam int unsigned NREGS_DEF  = 32;
    localparam int unsigned SEL_W_DEF  = 5;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned RD_LAT_DEF = 0;

    localparam logic [31:0] HALT_PC_DEF = 32'hf000_0100;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SEL   = 3'd1;
    localparam state_t ST_OUT   = 3'd2;
    localparam state_t ST_CKSUM = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/rf_dump_ctrl_if.sv
// -----------------------------------------------------------------------------
// rf_dump_ctrl_if
//   Valid/ready beat stream carrying one {index, data} register beat towards
//   a UART/display sink.
//   Signals:
//     out_valid  beat available            (master -> slave)
//     out_ready  sink accepts beat         (slave  -> master)
//     out_sel    register index of beat    (master -> slave)
//     out_data   register value of beat    (master -> slave)
//     out_last   final beat of the dump    (master -> slave)
//     out_cksum  beat carries the checksum (master -> slave)
//   Modports: master (sequencer side), slave (sink side).
// -----------------------------------------------------------------------------
interface rf_dump_ctrl_if
    import rf_dump_pkg::*;
#(
    parameter int unsigned SEL_W  = SEL_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic              out_valid;
    logic              out_ready;
    logic [SEL_W-1:0]  out_sel;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_cksum;

    modport master (
        output out_valid, out_sel, out_data, out_last, out_cksum,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_sel, out_data, out_last, out_cksum,
        output out_ready
    );

endinterface

// File: rtl/rf_dump_halt_det.sv
// -----------------------------------------------------------------------------
// rf_dump_halt_det
//   Dump trigger generator. Compares the core PC against the halt sentinel
//   and fires once on the first cycle the PC equals it; a PC parked on the
//   sentinel does not retrigger. The explicit start pulse is ORed in.
//   Ports:
//     clk      in   clock, rising edge
//     rstn     in   synchronous reset, active low
//     start    in   one-cycle dump request
//     pc       in   core PC
//     trigger  out  dump request (combinational)
// -----------------------------------------------------------------------------
module rf_dump_halt_det
    import rf_dump_pkg::*;
#(
    parameter logic [31:0] HALT_PC = HALT_PC_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [31:0] pc,
    output logic        trigger
);

    logic pc_hit;
    logic pc_hit_q, pc_hit_d;

    assign pc_hit   = (pc == HALT_PC);
    assign pc_hit_d = pc_hit;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_hit_q <= 1'b0;
        end else begin
            pc_hit_q <= pc_hit_d;
        end
    end

    // Rising edge of the PC match only.
    assign trigger = start | (pc_hit & ~pc_hit_q);

endmodule

// File: rtl/rf_dump_ctrl.sv
// -----------------------------------------------------------------------------
// rf_dump_ctrl
//   Register-file dump sequencer for the single-cycle core top (sccomp).
//   On a start pulse, or when the PC first reaches HALT_PC, scans registers
//   0..NREGS-1 through reg_sel/reg_data and emits one {index, data} beat per
//   register on the out_if stream.
//   Optional feature macro: RF_DUMP_CKSUM_EN -- appends a beat carrying the
//   XOR of all dumped words (out_cksum=1, out_last=1, out_sel=0).
//   Ports:
//     clk       in   clock, rising edge
//     rstn      in   synchronous reset, active low
//     start     in   one-cycle dump request
//     pc        in   core PC, for halt detection
//     reg_sel   out  register index to sccomp (0 outside the select phase)
//     reg_data  in   register value from sccomp, valid RD_LAT cycles after reg_sel
//     out_if    master stream: out_valid/out_ready/out_sel/out_data/out_last/out_cksum
//     busy      out  dump in progress
//     done      out  one-cycle pulse after the final handshake
// -----------------------------------------------------------------------------
module rf_dump_ctrl
    import rf_dump_pkg::*;
#(
    parameter int unsigned NREGS   = NREGS_DEF,
    parameter int unsigned SEL_W   = SEL_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned RD_LAT  = RD_LAT_DEF,
    parameter logic [31:0] HALT_PC = HALT_PC_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [31:0]       pc,
    output logic [SEL_W-1:0]  reg_sel,
    input  logic [DATA_W-1:0] reg_data,
    rf_dump_ctrl_if.master    out_if,
    output logic              busy,
    output logic              done
);

    localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NREGS - 1);
    localparam logic [1:0]       WAIT_LAST = 2'(RD_LAT);

    logic trigger;

    state_t            state_q,    state_d;
    logic [SEL_W-1:0]  idx_q,      idx_d;
    logic [1:0]        wait_q,     wait_d;
    logic [SEL_W-1:0]  out_sel_q,  out_sel_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
`ifdef RF_DUMP_CKSUM_EN
    logic [DATA_W-1:0] cksum_q,     cksum_d;
    logic              out_cksum_q, out_cksum_d;
`endif

    rf_dump_halt_det #(
        .HALT_PC (HALT_PC)
    ) u_halt_det (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .pc      (pc),
        .trigger (trigger)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wait_d     = wait_q;
        out_sel_d  = out_sel_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
`ifdef RF_DUMP_CKSUM_EN
        cksum_d     = cksum_q;
        out_cksum_d = out_cksum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // Triggers arriving in any other state are dropped.
                if (trigger) begin
                    idx_d   = '0;
                    wait_d  = '0;
                    state_d = ST_SEL;
`ifdef RF_DUMP_CKSUM_EN
                    cksum_d = '0;
`endif
                end
            end

            ST_SEL: begin
                // reg_sel is held for RD_LAT+1 cycles; capture on the last.
                if (wait_q == WAIT_LAST) begin
                    out_sel_d  = idx_q;
                    out_data_d = reg_data;
`ifdef RF_DUMP_CKSUM_EN
                    out_last_d  = 1'b0;
                    out_cksum_d = 1'b0;
                    cksum_d     = cksum_q ^ reg_data;
`else
                    out_last_d  = (idx_q == LAST_IDX);
`endif
                    state_d = ST_OUT;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end

            ST_OUT: begin
                if (out_if.out_ready) begin
                    if (idx_q == LAST_IDX) begin
`ifdef RF_DUMP_CKSUM_EN
                        out_sel_d   = '0;
                        out_data_d  = cksum_q;
                        out_last_d  = 1'b1;
                        out_cksum_d = 1'b1;
                        state_d     = ST_CKSUM;
`else
                        state_d     = ST_DONE;
`endif
                    end else begin
                        idx_d   = idx_q + SEL_W'(1);
                        wait_d  = '0;
                        state_d = ST_SEL;
                    end
                end
            end

            ST_CKSUM: begin
`ifdef RF_DUMP_CKSUM_EN
                if (out_if.out_ready) begin
                    state_d = ST_DONE;
                end
`else
                state_d = ST_IDLE;
`endif
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            wait_q     <= '0;
            out_sel_q  <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
`ifdef RF_DUMP_CKSUM_EN
            cksum_q     <= '0;
            out_cksum_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wait_q     <= wait_d;
            out_sel_q  <= out_sel_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
`ifdef RF_DUMP_CKSUM_EN
            cksum_q     <= cksum_d;
            out_cksum_q <= out_cksum_d;
`endif
        end
    end

    assign reg_sel          = (state_q == ST_SEL) ? idx_q : '0;
    assign out_if.out_valid = (state_q == ST_OUT) || (state_q == ST_CKSUM);
    assign out_if.out_sel   = out_sel_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_last  = out_last_q;
`ifdef RF_DUMP_CKSUM_EN
    assign out_if.out_cksum = out_cksum_q;
`else
    assign out_if.out_cksum = 1'b0;
`endif
    assign busy             = (state_q != ST_IDLE);
    assign done             = (state_q == ST_DONE);

endmodule

// File: tb/tb_rf_dump_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rf_dump_ctrl
//   Directed bench for rf_dump_ctrl (RD_LAT=0). A small register-file model
//   answers reg_sel combinationally with rf[i] = i * 32'h01010101.
// -----------------------------------------------------------------------------
module tb_rf_dump_ctrl;

    localparam int          NREGS = 32;
`ifdef RF_DUMP_CKSUM_EN
    localparam int          NB    = NREGS + 1;
`else
    localparam int          NB    = NREGS;
`endif
    localparam logic [31:0] HALT  = 32'hf000_0100;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [31:0] pc;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic        busy;
    logic        done;

    rf_dump_ctrl_if #(.SEL_W(5), .DATA_W(32)) bus ();

    rf_dump_ctrl #(
        .NREGS   (32),
        .SEL_W   (5),
        .DATA_W  (32),
        .RD_LAT  (0),
        .HALT_PC (32'hf000_0100)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .pc       (pc),
        .reg_sel  (reg_sel),
        .reg_data (reg_data),
        .out_if   (bus),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    logic [31:0] rf [NREGS];
    logic [31:0] xor_all;

    assign reg_data = rf[reg_sel];

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_sel(input int e);
        return (e < NREGS) ? 32'(e) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_data(input int e);
        return (e < NREGS) ? rf[e] : xor_all;
    endfunction

    function automatic logic [31:0] exp_last(input int e);
        return (e == NB - 1) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] exp_ck(input int e);
        return (e == NREGS) ? 32'd1 : 32'd0;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Follows one dump beat by beat, starting at the negedge right after the
    // trigger edge. stall_at: beat held with out_ready=0 for 5 cycles.
    // rst_at: beat at which rstn is pulsed low for one cycle (abort).
    task automatic run_dump(input int stall_at, input int rst_at);
        int e, last_hs, dones, cyc, tail;
        bit fin;
        e = 0; last_hs = -1; dones = 0; cyc = 0; tail = 0; fin = 1'b0;
        bus.out_ready = 1'b1;
        while (!fin && cyc < 400) begin
            if (bus.out_valid) begin
                chk($sformatf("b%0d gap", e),   32'(cyc - last_hs), 32'd2);
                chk($sformatf("b%0d sel", e),   32'(bus.out_sel),   exp_sel(e));
                chk($sformatf("b%0d data", e),  bus.out_data,       exp_data(e));
                chk($sformatf("b%0d last", e),  32'(bus.out_last),  exp_last(e));
                chk($sformatf("b%0d cksum", e), 32'(bus.out_cksum), exp_ck(e));
                chk($sformatf("b%0d busy", e),  32'(busy),          32'd1);
                if (e == rst_at) begin
                    rstn = 1'b0;
                    bus.out_ready = 1'b0;
                    @(negedge clk);
                    chk("abort valid",   32'(bus.out_valid), 32'd0);
                    chk("abort busy",    32'(busy),          32'd0);
                    chk("abort done",    32'(done),          32'd0);
                    chk("abort reg_sel", 32'(reg_sel),       32'd0);
                    rstn = 1'b1;
                    bus.out_ready = 1'b1;
                    return;
                end
                if (e == stall_at) begin
                    bus.out_ready = 1'b0;
                    for (int s = 0; s < 5; s++) begin
                        @(negedge clk);
                        cyc++;
                        chk($sformatf("stall%0d valid", s), 32'(bus.out_valid), 32'd1);
                        chk($sformatf("stall%0d sel", s),   32'(bus.out_sel),   exp_sel(e));
                        chk($sformatf("stall%0d data", s),  bus.out_data,       exp_data(e));
                        chk($sformatf("stall%0d last", s),  32'(bus.out_last),  exp_last(e));
                    end
                    bus.out_ready = 1'b1;
                end
                last_hs = cyc;
                e++;
            end
            if (done) begin
                dones++;
                chk("done gap",   32'(cyc - last_hs), 32'd1);
                chk("done beats", 32'(e),             32'(NB));
            end
            if (dones > 0) begin
                tail++;
                if (tail > 3) fin = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        chk("dump beats", 32'(e),     32'(NB));
        chk("dump dones", 32'(dones), 32'd1);
    endtask

    // Free-running window with out_ready=1: counts accepted beats and done
    // pulses; start is pulsed on cycle start_at (negative: never).
    task automatic count_window(input int ncyc, input int start_at,
                                output int hs, output int dn);
        hs = 0; dn = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            start = (i == start_at);
            if (bus.out_valid) hs++;
            if (done) dn++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        int hs, dn;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, dn;
        xor_all = '0;
        for (int i = 0; i < NREGS; i++) begin
            rf[i]   = 32'(i) * 32'h0101_0101;
            xor_all = xor_all ^ rf[i];
        end

        rstn = 1'b0; start = 1'b0; pc = '0; bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst reg_sel",   32'(reg_sel),       32'd0);
        chk("rst valid",     32'(bus.out_valid), 32'd0);
        chk("rst busy",      32'(busy),          32'd0);
        chk("rst done",      32'(done),          32'd0);
        chk("rst cksum",     32'(bus.out_cksum), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Full dump, sink always ready
        pulse_start();
        chk("sel phase busy", 32'(busy), 32'd1);
        run_dump(-1, -1);

        // Backpressure on beat 7
        pulse_start();
        run_dump(7, -1);

        // Reset while beat 10 is valid, then a fresh dump from index 0
        pulse_start();
        run_dump(-1, 10);
        repeat (3) begin
            @(negedge clk);
            chk("post-abort done", 32'(done), 32'd0);
            chk("post-abort busy", 32'(busy), 32'd0);
        end
        pulse_start();
        run_dump(-1, -1);

        // PC parked on the halt sentinel, extra start mid-dump
        pc = HALT;
        count_window(200, 20, hs, dn);
        chk("halt beats", 32'(hs), 32'(NB));
        chk("halt dones", 32'(dn), 32'd1);
        chk("halt idle",  32'(busy), 32'd0);

        // Start and PC hit in the same cycle give a single dump
        pc = '0;
        @(negedge clk);
        pc = HALT;
        count_window(120, 0, hs, dn);
        chk("coinc beats", 32'(hs), 32'(NB));
        chk("coinc dones", 32'(dn), 32'd1);
        pc = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
